// File: rtl/mor1kx_spr_pkg.sv
// Shared SPR access definitions: FSM states, group-0 register indices and address field layout.
package mor1kx_spr_pkg;

   localparam int unsigned SPR_ADDR_W    = 16;
   localparam int unsigned SPR_DATA_W    = 32;
   localparam int unsigned SPR_INDEX_W   = 11;
   localparam int unsigned SPR_GROUP_W   = 5;
   localparam int unsigned SPR_GROUP_LSB = 11;

   localparam int unsigned IDX_VR       = 0;
   localparam int unsigned IDX_UPR      = 1;
   localparam int unsigned IDX_CPUCFGR  = 2;
   localparam int unsigned IDX_DMMUCFGR = 3;
   localparam int unsigned IDX_IMMUCFGR = 4;
   localparam int unsigned IDX_DCCFGR   = 5;
   localparam int unsigned IDX_ICCFGR   = 6;
   localparam int unsigned IDX_DCFGR    = 7;
   localparam int unsigned IDX_PCCFGR   = 8;
   localparam int unsigned IDX_VR2      = 9;
   localparam int unsigned IDX_AVR      = 10;
   localparam int unsigned IDX_FPCSR    = 20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOCAL,
      S_BUS,
      S_DONE
   } state_t;

   function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [SPR_ADDR_W-1:0] addr);
      return addr[SPR_GROUP_LSB +: SPR_GROUP_W];
   endfunction

   function automatic logic [SPR_INDEX_W-1:0] spr_index(input logic [SPR_ADDR_W-1:0] addr);
      return addr[SPR_INDEX_W-1:0];
   endfunction

endpackage

// File: rtl/mor1kx_spr_access_if.sv
// Requester ports and SPR bus of the access sequencer.
// The debug port exists only when MOR1KX_SPR_DU_PORT_EN is defined.
interface mor1kx_spr_access_if;
   import mor1kx_spr_pkg::*;

   logic                  cpu_req_i;
   logic                  cpu_we_i;
   logic [SPR_ADDR_W-1:0] cpu_addr_i;
   logic [SPR_DATA_W-1:0] cpu_wdat_i;
   logic                  cpu_ack_o;
   logic                  cpu_err_o;
   logic [SPR_DATA_W-1:0] cpu_rdat_o;
`ifdef MOR1KX_SPR_DU_PORT_EN
   logic                  du_req_i;
   logic                  du_we_i;
   logic [SPR_ADDR_W-1:0] du_addr_i;
   logic [SPR_DATA_W-1:0] du_wdat_i;
   logic                  du_ack_o;
   logic                  du_err_o;
   logic [SPR_DATA_W-1:0] du_rdat_o;
`endif
   logic                  spr_bus_stb_o;
   logic                  spr_bus_we_o;
   logic [SPR_ADDR_W-1:0] spr_bus_addr_o;
   logic [SPR_DATA_W-1:0] spr_bus_dat_o;
   logic                  spr_bus_ack_i;
   logic [SPR_DATA_W-1:0] spr_bus_dat_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdat_i,
      output cpu_ack_o, cpu_err_o, cpu_rdat_o,
`ifdef MOR1KX_SPR_DU_PORT_EN
      input  du_req_i, du_we_i, du_addr_i, du_wdat_i,
      output du_ack_o, du_err_o, du_rdat_o,
`endif
      output spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o,
      input  spr_bus_ack_i, spr_bus_dat_i
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdat_i,
      input  cpu_ack_o, cpu_err_o, cpu_rdat_o,
`ifdef MOR1KX_SPR_DU_PORT_EN
      output du_req_i, du_we_i, du_addr_i, du_wdat_i,
      input  du_ack_o, du_err_o, du_rdat_o,
`endif
      input  spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o,
      output spr_bus_ack_i, spr_bus_dat_i
   );

endinterface

// File: rtl/mor1kx_spr_cfg_decode.sv
// Group-0 configuration register lookup: flags a local hit and returns the cfg value.
module mor1kx_spr_cfg_decode
   import mor1kx_spr_pkg::*;
(
   input  logic [SPR_ADDR_W-1:0] addr,
   input  logic [SPR_DATA_W-1:0] cfg_vr_i,
   input  logic [SPR_DATA_W-1:0] cfg_vr2_i,
   input  logic [SPR_DATA_W-1:0] cfg_upr_i,
   input  logic [SPR_DATA_W-1:0] cfg_cpucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dmmucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_immucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_iccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dcfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_pccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_fpcsr_i,
   input  logic [SPR_DATA_W-1:0] cfg_avr_i,
   output logic                  hit_c,
   output logic [SPR_DATA_W-1:0] value_c
);

   always_comb begin
      hit_c   = 1'b0;
      value_c = '0;
      if (spr_group(addr) == '0) begin
         hit_c = 1'b1;
         case (spr_index(addr))
            SPR_INDEX_W'(IDX_VR):       value_c = cfg_vr_i;
            SPR_INDEX_W'(IDX_UPR):      value_c = cfg_upr_i;
            SPR_INDEX_W'(IDX_CPUCFGR):  value_c = cfg_cpucfgr_i;
            SPR_INDEX_W'(IDX_DMMUCFGR): value_c = cfg_dmmucfgr_i;
            SPR_INDEX_W'(IDX_IMMUCFGR): value_c = cfg_immucfgr_i;
            SPR_INDEX_W'(IDX_DCCFGR):   value_c = cfg_dccfgr_i;
            SPR_INDEX_W'(IDX_ICCFGR):   value_c = cfg_iccfgr_i;
            SPR_INDEX_W'(IDX_DCFGR):    value_c = cfg_dcfgr_i;
            SPR_INDEX_W'(IDX_PCCFGR):   value_c = cfg_pccfgr_i;
            SPR_INDEX_W'(IDX_VR2):      value_c = cfg_vr2_i;
            SPR_INDEX_W'(IDX_AVR):      value_c = cfg_avr_i;
            SPR_INDEX_W'(IDX_FPCSR):    value_c = cfg_fpcsr_i;
            default:                    hit_c   = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mor1kx_spr_access.sv
// SPR access sequencer: local group-0 config reads, SPR bus accesses with ack timeout.
// Define MOR1KX_SPR_DU_PORT_EN to add the debug requester (priority over the CPU).
module mor1kx_spr_access
   import mor1kx_spr_pkg::*;
#(
   parameter int unsigned OPTION_SPR_TIMEOUT   = 16,
   parameter int unsigned OPTION_TIMEOUT_WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   mor1kx_spr_access_if.slave    spr,
   input  logic [SPR_DATA_W-1:0] cfg_vr_i,
   input  logic [SPR_DATA_W-1:0] cfg_vr2_i,
   input  logic [SPR_DATA_W-1:0] cfg_upr_i,
   input  logic [SPR_DATA_W-1:0] cfg_cpucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dmmucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_immucfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_iccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_dcfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_pccfgr_i,
   input  logic [SPR_DATA_W-1:0] cfg_fpcsr_i,
   input  logic [SPR_DATA_W-1:0] cfg_avr_i,
   output logic                  busy_o
);

   state_t                          state;
   logic                            cap_we;
   logic [SPR_DATA_W-1:0]           cap_cfg;
   logic [OPTION_TIMEOUT_WIDTH-1:0] cnt;

   logic                  req_c, req_we_c, hit_c;
   logic [SPR_ADDR_W-1:0] req_addr_c;
   logic [SPR_DATA_W-1:0] req_wdat_c, cfg_val_c;
   logic                  done_c, done_err_c, cpu_done_c;
   logic [SPR_DATA_W-1:0] done_dat_c;

`ifdef MOR1KX_SPR_DU_PORT_EN
   logic cap_du;
   logic du_done_c;

   // Fixed priority: debug wins, the CPU request simply stays pending.
   assign req_c      = spr.du_req_i | spr.cpu_req_i;
   assign req_we_c   = spr.du_req_i ? spr.du_we_i   : spr.cpu_we_i;
   assign req_addr_c = spr.du_req_i ? spr.du_addr_i : spr.cpu_addr_i;
   assign req_wdat_c = spr.du_req_i ? spr.du_wdat_i : spr.cpu_wdat_i;
   assign cpu_done_c = done_c & ~cap_du;
   assign du_done_c  = done_c & cap_du;
`else
   assign req_c      = spr.cpu_req_i;
   assign req_we_c   = spr.cpu_we_i;
   assign req_addr_c = spr.cpu_addr_i;
   assign req_wdat_c = spr.cpu_wdat_i;
   assign cpu_done_c = done_c;
`endif

   mor1kx_spr_cfg_decode u_cfg_decode (
      .addr           (req_addr_c),
      .cfg_vr_i       (cfg_vr_i),
      .cfg_vr2_i      (cfg_vr2_i),
      .cfg_upr_i      (cfg_upr_i),
      .cfg_cpucfgr_i  (cfg_cpucfgr_i),
      .cfg_dmmucfgr_i (cfg_dmmucfgr_i),
      .cfg_immucfgr_i (cfg_immucfgr_i),
      .cfg_dccfgr_i   (cfg_dccfgr_i),
      .cfg_iccfgr_i   (cfg_iccfgr_i),
      .cfg_dcfgr_i    (cfg_dcfgr_i),
      .cfg_pccfgr_i   (cfg_pccfgr_i),
      .cfg_fpcsr_i    (cfg_fpcsr_i),
      .cfg_avr_i      (cfg_avr_i),
      .hit_c          (hit_c),
      .value_c        (cfg_val_c)
   );

   // Completion of the captured request; a bus ack beats a coincident timeout.
   always_comb begin
      done_c     = 1'b0;
      done_err_c = 1'b0;
      done_dat_c = '0;
      case (state)
         S_LOCAL: begin
            done_c     = 1'b1;
            done_err_c = cap_we;
            done_dat_c = cap_we ? '0 : cap_cfg;
         end
         S_BUS: begin
            if (spr.spr_bus_ack_i) begin
               done_c     = 1'b1;
               done_dat_c = cap_we ? '0 : spr.spr_bus_dat_i;
            end else if (cnt == OPTION_TIMEOUT_WIDTH'(OPTION_SPR_TIMEOUT - 1)) begin
               done_c     = 1'b1;
               done_err_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         cap_we             <= 1'b0;
         cap_cfg            <= '0;
         cnt                <= '0;
         busy_o             <= 1'b0;
         spr.spr_bus_stb_o  <= 1'b0;
         spr.spr_bus_we_o   <= 1'b0;
         spr.spr_bus_addr_o <= '0;
         spr.spr_bus_dat_o  <= '0;
`ifdef MOR1KX_SPR_DU_PORT_EN
         cap_du             <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_c) begin
                  cap_we             <= req_we_c;
                  cap_cfg            <= cfg_val_c;
                  spr.spr_bus_addr_o <= req_addr_c;
                  spr.spr_bus_dat_o  <= req_wdat_c;
                  busy_o             <= 1'b1;
`ifdef MOR1KX_SPR_DU_PORT_EN
                  cap_du             <= spr.du_req_i;
`endif
                  if (hit_c) begin
                     state <= S_LOCAL;
                  end else begin
                     state             <= S_BUS;
                     cnt               <= '0;
                     spr.spr_bus_stb_o <= 1'b1;
                     spr.spr_bus_we_o  <= req_we_c;
                  end
               end
            end
            S_LOCAL: state <= S_DONE;
            S_BUS: begin
               if (done_c) begin
                  state             <= S_DONE;
                  spr.spr_bus_stb_o <= 1'b0;
                  spr.spr_bus_we_o  <= 1'b0;
               end else if (cnt != '1) begin
                  cnt <= cnt + OPTION_TIMEOUT_WIDTH'(1);
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Per-owner response registers; rdata holds until that owner's next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spr.cpu_ack_o  <= 1'b0;
         spr.cpu_err_o  <= 1'b0;
         spr.cpu_rdat_o <= '0;
`ifdef MOR1KX_SPR_DU_PORT_EN
         spr.du_ack_o   <= 1'b0;
         spr.du_err_o   <= 1'b0;
         spr.du_rdat_o  <= '0;
`endif
      end else begin
         spr.cpu_ack_o <= cpu_done_c;
         spr.cpu_err_o <= cpu_done_c & done_err_c;
         if (cpu_done_c)
            spr.cpu_rdat_o <= done_dat_c;
`ifdef MOR1KX_SPR_DU_PORT_EN
         spr.du_ack_o <= du_done_c;
         spr.du_err_o <= du_done_c & done_err_c;
         if (du_done_c)
            spr.du_rdat_o <= done_dat_c;
`endif
      end
   end

endmodule

// File: tb/tb_mor1kx_spr_access.sv
// Directed + randomized bench for mor1kx_spr_access against a transaction-level model.
// Define MOR1KX_SPR_DU_PORT_EN to also exercise debug/CPU arbitration.
module tb_mor1kx_spr_access;
   localparam int unsigned T = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic [31:0] cfg [12];
   int unsigned loc_addr [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 20};
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mor1kx_spr_access_if bus_if ();

   // cfg index order follows loc_addr: VR, UPR, CPUCFGR, DMMU, IMMU, DC, IC, DCFGR, PCCFGR, VR2, AVR, FPCSR
   mor1kx_spr_access #(.OPTION_SPR_TIMEOUT(T), .OPTION_TIMEOUT_WIDTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .spr            (bus_if),
      .cfg_vr_i       (cfg[0]),
      .cfg_upr_i      (cfg[1]),
      .cfg_cpucfgr_i  (cfg[2]),
      .cfg_dmmucfgr_i (cfg[3]),
      .cfg_immucfgr_i (cfg[4]),
      .cfg_dccfgr_i   (cfg[5]),
      .cfg_iccfgr_i   (cfg[6]),
      .cfg_dcfgr_i    (cfg[7]),
      .cfg_pccfgr_i   (cfg[8]),
      .cfg_vr2_i      (cfg[9]),
      .cfg_avr_i      (cfg[10]),
      .cfg_fpcsr_i    (cfg[11]),
      .busy_o         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_local(input logic [15:0] addr, output bit hit, output logic [31:0] val);
      hit = 1'b0;
      val = '0;
      for (int i = 0; i < 12; i++)
         if (addr == 16'(loc_addr[i])) begin
            hit = 1'b1;
            val = cfg[i];
         end
   endfunction

   // One CPU access; ack_after = stb cycle on which the bus acks (0 = never).
   task automatic txn(input bit we, input logic [15:0] addr, input logic [31:0] wdat,
                      input int ack_after, input int lat_extra, input bit b2b, input bit noise);
      bit hit, acked, got_err;
      logic [31:0] cv, bdat, exp_rdat, got_rdat;
      int exp_stb, exp_lat, stb_cnt, lat;
      model_local(addr, hit, cv);
      acked    = !hit && ack_after >= 1 && ack_after <= int'(T);
      exp_stb  = hit ? 0 : (acked ? ack_after : int'(T));
      exp_lat  = (hit ? 2 : exp_stb + 1) + lat_extra;
      bdat     = $urandom;
      exp_rdat = we ? 32'h0 : hit ? cv : acked ? bdat : 32'h0;
      stb_cnt  = 0;
      lat      = -1;
      got_err  = 1'b0;
      got_rdat = '0;
      bus_if.cpu_req_i     = 1'b1;
      bus_if.cpu_we_i      = we;
      bus_if.cpu_addr_i    = addr;
      bus_if.cpu_wdat_i    = wdat;
      bus_if.spr_bus_ack_i = noise;
      bus_if.spr_bus_dat_i = ~bdat;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(posedge clk); #1;
         bus_if.spr_bus_ack_i = noise;
         bus_if.spr_bus_dat_i = ~bdat;
         if (bus_if.spr_bus_stb_o) begin
            stb_cnt++;
            if (stb_cnt == 1) begin
               check("bus_addr", 32'(bus_if.spr_bus_addr_o), 32'(addr));
               check("bus_we", 32'(bus_if.spr_bus_we_o), 32'(we));
               if (we) check("bus_wdat", bus_if.spr_bus_dat_o, wdat);
            end
            if (stb_cnt == ack_after) begin
               bus_if.spr_bus_ack_i = 1'b1;
               bus_if.spr_bus_dat_i = bdat;
            end
         end
         if (bus_if.cpu_ack_o) begin
            lat      = c;
            got_err  = bus_if.cpu_err_o;
            got_rdat = bus_if.cpu_rdat_o;
            bus_if.cpu_req_i = 1'b0;
         end
      end
      bus_if.spr_bus_ack_i = 1'b0;
      check("ack_latency", 32'(lat), 32'(exp_lat));
      check("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
      check("err", 32'(got_err), 32'(hit ? we : !acked));
      check("rdat", got_rdat, exp_rdat);
      if (!b2b) begin
         @(posedge clk); #1;
         check("ack_pulse", 32'(bus_if.cpu_ack_o), 32'h0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 12; i++) cfg[i] = $urandom;
      bus_if.cpu_req_i     = 1'b0;
      bus_if.cpu_we_i      = 1'b0;
      bus_if.cpu_addr_i    = '0;
      bus_if.cpu_wdat_i    = '0;
      bus_if.spr_bus_ack_i = 1'b0;
      bus_if.spr_bus_dat_i = '0;
`ifdef MOR1KX_SPR_DU_PORT_EN
      bus_if.du_req_i  = 1'b0;
      bus_if.du_we_i   = 1'b0;
      bus_if.du_addr_i = '0;
      bus_if.du_wdat_i = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(bus_if.cpu_ack_o), 0);
      check("rst_err", 32'(bus_if.cpu_err_o), 0);
      check("rst_rdat", bus_if.cpu_rdat_o, 0);
      check("rst_stb", 32'(bus_if.spr_bus_stb_o), 0);
      check("rst_we", 32'(bus_if.spr_bus_we_o), 0);
      check("rst_addr", 32'(bus_if.spr_bus_addr_o), 0);
      check("rst_dat", bus_if.spr_bus_dat_o, 0);
      check("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      txn(1'b0, 16'h0002, 32'h0, 0, 0, 1'b0, 1'b0);
      txn(1'b1, 16'h0001, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h0001, 32'h0, 0, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h2801, 32'h0, 3, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h2801, 32'h0, 0, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h2801, 32'h0, T, 0, 1'b0, 1'b0);
      txn(1'b1, 16'h2810, $urandom, 2, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h000B, 32'h0, 1, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h000A, 32'h0, 0, 0, 1'b0, 1'b1);
      txn(1'b0, 16'h0000, 32'h0, 0, 0, 1'b1, 1'b0);
      txn(1'b0, 16'h0014, 32'h0, 0, 1, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         logic [15:0] a;
         a = $urandom_range(0, 1) ? 16'(loc_addr[$urandom_range(0, 11)]) : 16'($urandom);
         txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, T + 1)), 0, 1'b0, 1'b0);
      end

      // Reset in the middle of a bus access.
      bus_if.cpu_req_i  = 1'b1;
      bus_if.cpu_we_i   = 1'b0;
      bus_if.cpu_addr_i = 16'h3003;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_stb", 32'(bus_if.spr_bus_stb_o), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stb", 32'(bus_if.spr_bus_stb_o), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_addr", 32'(bus_if.spr_bus_addr_o), 0);
      check("mid_rst_ack", 32'(bus_if.cpu_ack_o), 0);
      check("mid_rst_rdat", bus_if.cpu_rdat_o, 0);
      bus_if.cpu_req_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(1'b0, 16'h0009, 32'h0, 0, 0, 1'b0, 1'b0);
      txn(1'b0, 16'h4005, 32'h0, 2, 0, 1'b0, 1'b0);

`ifdef MOR1KX_SPR_DU_PORT_EN
      begin : du_test
         int du_at, cpu_at;
         logic [31:0] du_r, cpu_r;
         du_at  = -1;
         cpu_at = -1;
         du_r   = '0;
         cpu_r  = '0;
         bus_if.du_req_i   = 1'b1;
         bus_if.du_we_i    = 1'b0;
         bus_if.du_addr_i  = 16'h0003;
         bus_if.cpu_req_i  = 1'b1;
         bus_if.cpu_we_i   = 1'b0;
         bus_if.cpu_addr_i = 16'h0007;
         for (int c = 1; c <= 20 && cpu_at < 0; c++) begin
            @(posedge clk); #1;
            check("ack_exclusive", 32'(bus_if.du_ack_o & bus_if.cpu_ack_o), 0);
            if (bus_if.du_ack_o) begin
               du_at = c;
               du_r  = bus_if.du_rdat_o;
               bus_if.du_req_i = 1'b0;
            end
            if (bus_if.cpu_ack_o) begin
               cpu_at = c;
               cpu_r  = bus_if.cpu_rdat_o;
               bus_if.cpu_req_i = 1'b0;
            end
         end
         check("du_latency", 32'(du_at), 2);
         check("cpu_after_du", 32'(cpu_at), 5);
         check("du_rdat", du_r, cfg[3]);
         check("cpu_rdat_arb", cpu_r, cfg[7]);
         @(posedge clk); #1;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mor1kx_spr_access.md
# mor1kx_spr_access

SPR access sequencer between requesters and the configuration/special-purpose register space. It accepts SPR read/write requests from the CPU control stage and, optionally, the debug unit, and answers group-0 configuration registers locally from the configuration-register outputs. All other addresses go to the SPR bus with an ack handshake and a timeout. Each request completes with a registered, single-cycle acknowledge.

## Interface
- OPTION_SPR_TIMEOUT, 16: bus cycles without `spr_bus_ack_i` before abort; range 2..255.
- OPTION_TIMEOUT_WIDTH, 8: timeout counter width.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req_i / cpu_we_i  in  1/1  CPU request (level, held until ack) / write
- cpu_addr_i / cpu_wdat_i  in  16/32  SPR address {group[15:11], index[10:0]} / write data
- cpu_ack_o / cpu_err_o / cpu_rdat_o  out  1/1/32  completion pulse / error / read data
- du_req_i, du_we_i, du_addr_i, du_wdat_i, du_ack_o, du_err_o, du_rdat_o: debug port, same widths (MOR1KX_SPR_DU_PORT_EN only)
- cfg_vr_i, cfg_vr2_i, cfg_upr_i, cfg_cpucfgr_i, cfg_dmmucfgr_i, cfg_immucfgr_i, cfg_dccfgr_i, cfg_iccfgr_i, cfg_dcfgr_i, cfg_pccfgr_i, cfg_fpcsr_i, cfg_avr_i  in  32 each  static configuration values
- spr_bus_stb_o / spr_bus_we_o  out  1/1  bus strobe / write
- spr_bus_addr_o / spr_bus_dat_o  out  16/32  bus address / write data
- spr_bus_ack_i / spr_bus_dat_i  in  1/32  bus ack / read data
- busy_o  out  1  high in any state other than IDLE

## Operation
- Local table (group 0): idx 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR, 20 FPCSR. Every other address goes to the bus.
- Local read returns the matching cfg input. Local write is dropped, acked, err=1.
- FSM states: IDLE, LOCAL, BUS, DONE.
  - IDLE, request present: capture owner/we/addr/wdat. Go to LOCAL on a table hit, else BUS.
  - LOCAL: load response, go to DONE.
  - BUS: stb=1, addr/we/dat from the capture registers. On ack: latch spr_bus_dat_i (reads) and go to DONE. When the counter reaches OPTION_SPR_TIMEOUT: rdata=0, err=1, go to DONE.
  - DONE: pulse owner's ack_o for 1 cycle with err/rdata valid, then return to IDLE.
- Arbitration in IDLE is fixed priority, debug over CPU. The losing request stays pending.
- Request change or deassertion after capture is ignored. The captured request always completes.
- Timeout counter is cleared on entry to BUS and saturates.
- rdata outputs hold their last value until the next completion for that owner.
- Writes return rdata=0.

## Timing
- Reset (rst_n low, async): state=IDLE, all ack/err/stb/we/busy_o=0, addr=0, all data outputs=0.
- Local access: request seen in IDLE at cycle N, ack_o at N+2.
- Bus access: stb from N+1. Bus ack at cycle M gives ack_o at M+1, stb low at M+1.
- Bus ack in the same cycle the timeout hits: ack wins, err=0.
- Bus ack outside BUS is ignored.
- Back-to-back requests: next capture possible the cycle after DONE. Minimum 3-cycle local throughput.
- rst_n asserted mid-transaction aborts with no ack. The bus sees stb drop asynchronously.

## Configuration
- MOR1KX_SPR_DU_PORT_EN defined: debug port present and arbitrated as above.
- Not defined: du_* ports absent, CPU is the only requester, owner register removed.

## Structure
- Shared package (mor1kx_spr_pkg): state enum, group-0 index constants, SPR address field widths/positions.
- One natural sub-module, mor1kx_spr_cfg_decode: combinational address-to-cfg mux, outputs hit flag and 32-bit value.

## Test plan
- CPU read 0x0002 at cycle N: cpu_ack_o at N+2 with cfg_cpucfgr_i value, err=0, no spr_bus_stb_o.
- CPU write 0x0001, data 0xDEAD_BEEF: ack, err=1, no bus activity, next UPR read returns the unchanged cfg_upr_i.
- CPU read 0x2801, bus acks after 3 cycles with 0x1234_5678: stb high 3 cycles, ack_o one cycle later with that data, err=0.
- Bus never acks, OPTION_SPR_TIMEOUT=4: stb high 4 cycles, then ack_o with err=1, rdata=0. Repeat with ack on the timeout cycle: err=0.
- Debug and CPU request together (DU_PORT_EN): debug served first, CPU served right after, each receives only its own ack.
- rst_n low during BUS: all outputs 0 immediately. After release, a new CPU read completes normally.
